// File: rtl/ucode_nest_if.sv
// ---------------------------------------------------------------------------
// ucode_nest_if
//   Bundle between the decode stage and the microcode nest sequencer.
//   The master side is the decode stage. It drives the stall, the start/end
//   instruction strobes and the instruction PC. It receives the memory
//   select, the nesting depth and the fetch-PC redirect.
//   The slave side is ucode_nest_sequencer.
//
//   Signals (master -> slave):
//     stall        pipeline stall; start/end strobes are ignored while high
//     start_valid  STARTMATMULk decoded
//     start_id     routine index k
//     end_valid    ENDMATMUL decoded
//     pc_in        PC of the start/end instruction
//   Signals (slave -> master):
//     im_sel       0 = normal memory, k+1 = routine k
//     active       nesting depth is non-zero
//     depth        current nesting depth
//     redir_valid  one-cycle fetch-PC redirect pulse
//     redir_pc     redirect target
//     err          one-cycle illegal-event pulse
//     wdt_abort    one-cycle watchdog abort pulse
// ---------------------------------------------------------------------------
interface ucode_nest_if #(
    parameter int XLEN         = 32,
    parameter int NUM_ROUTINES = 4,
    parameter int STACK_DEPTH  = 4
);
    localparam int ID_W  = (NUM_ROUTINES > 1) ? $clog2(NUM_ROUTINES) : 1;
    localparam int SEL_W = $clog2(NUM_ROUTINES + 1);
    localparam int DEP_W = $clog2(STACK_DEPTH + 1);

    logic             stall;
    logic             start_valid;
    logic [ID_W-1:0]  start_id;
    logic             end_valid;
    logic [XLEN-1:0]  pc_in;

    logic [SEL_W-1:0] im_sel;
    logic             active;
    logic [DEP_W-1:0] depth;
    logic             redir_valid;
    logic [XLEN-1:0]  redir_pc;
    logic             err;
    logic             wdt_abort;

    modport master (
        output stall, start_valid, start_id, end_valid, pc_in,
        input  im_sel, active, depth, redir_valid, redir_pc, err, wdt_abort
    );

    modport slave (
        input  stall, start_valid, start_id, end_valid, pc_in,
        output im_sel, active, depth, redir_valid, redir_pc, err, wdt_abort
    );
endinterface

// File: rtl/ucode_nest_sequencer.sv
// ---------------------------------------------------------------------------
// ucode_nest_sequencer
//   Microcode-mode sequencer with nested routine calls.
//   A start instruction pushes {return PC, current memory select} onto a
//   hardware return stack. It then selects routine k's instruction memory
//   and redirects fetch to ROUTINE_BASE. An end instruction pops the stack
//   and restores both. All outputs are registered. Their effect is visible
//   in the cycle after the accepted event.
//
//   Ports:
//     clk    clock
//     reset  synchronous, active-low reset
//     bus    ucode_nest_if.slave (decode strobes in; select/depth/redirect out)
//
//   Optional feature: define UCODE_WATCHDOG_EN to add a watchdog.
//   The watchdog flushes the whole nest after WDT_LIMIT non-stalled active
//   cycles without an accepted start/end. Fetch then returns to the
//   outermost return address.
// ---------------------------------------------------------------------------
module ucode_nest_sequencer #(
    parameter int              XLEN         = 32,
    parameter int              NUM_ROUTINES = 4,
    parameter int              STACK_DEPTH  = 4,
    parameter logic [XLEN-1:0] ROUTINE_BASE = '0,
    parameter int              WDT_LIMIT    = 1024
) (
    input logic         clk,
    input logic         reset,
    ucode_nest_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_ROUTINES + 1);
    localparam int DEP_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [DEP_W-1:0] DEPTH_MAX = DEP_W'(STACK_DEPTH);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    logic [SEL_W-1:0] sel_q;
    logic [DEP_W-1:0] depth_q;
    logic             redir_valid_q;
    logic [XLEN-1:0]  redir_pc_q;
    logic             err_q;
    logic             wdt_abort_q;

    // Return stack: entry i holds the caller of nesting level i+1.
    logic [XLEN-1:0]  stack_pc  [STACK_DEPTH];
    logic [SEL_W-1:0] stack_sel [STACK_DEPTH];

    logic             start_req;
    logic             end_req;
    logic             id_ok;
    logic             do_start;
    logic             do_end;
    logic             illegal;
    logic             wdt_fire;
    logic [IDX_W-1:0] push_idx;
    logic [IDX_W-1:0] pop_idx;

`ifdef UCODE_WATCHDOG_EN
    localparam int WDT_W = $clog2(WDT_LIMIT + 1);
    logic [WDT_W-1:0] wdt_cnt;
`else
    logic unused_wdt_limit;
    assign unused_wdt_limit = (WDT_LIMIT > 0);
`endif

    // ------------------------------------------------------------------
    // Event classification
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        wdt_fire = 1'b0;
`ifdef UCODE_WATCHDOG_EN
        // The cycle that would take the counter to WDT_LIMIT is the abort cycle.
        wdt_fire = (state == RUN) && !bus.stall && (wdt_cnt == WDT_W'(WDT_LIMIT - 1));
`endif
        start_req = bus.start_valid && !bus.stall;
        end_req   = bus.end_valid && !bus.stall;
        id_ok     = (32'(bus.start_id) < NUM_ROUTINES);

        // If start and end arrive together, the end wins and the start is dropped.
        do_end   = end_req && (depth_q != '0) && !wdt_fire;
        do_start = start_req && !end_req && id_ok && (depth_q < DEPTH_MAX) && !wdt_fire;
        illegal  = !wdt_fire &&
                   ((start_req && (end_req || !id_ok || (depth_q == DEPTH_MAX))) ||
                    (end_req && (depth_q == '0)));

        push_idx = IDX_W'(depth_q);
        pop_idx  = IDX_W'(depth_q - 1'b1);
    end

    // ------------------------------------------------------------------
    // Return stack storage
    // ------------------------------------------------------------------
    // NOTE: the stack array has no reset; depth_q alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (do_start) begin
            stack_pc[push_idx]  <= bus.pc_in + XLEN'(4);
            stack_sel[push_idx] <= sel_q;
        end
    end

    // ------------------------------------------------------------------
    // Nesting FSM with registered outputs
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            sel_q         <= '0;
            depth_q       <= '0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
            err_q         <= 1'b0;
            wdt_abort_q   <= 1'b0;
`ifdef UCODE_WATCHDOG_EN
            wdt_cnt       <= '0;
`endif
        end else begin
            redir_valid_q <= 1'b0;
            err_q         <= illegal;
            wdt_abort_q   <= 1'b0;
`ifdef UCODE_WATCHDOG_EN
            if (wdt_fire) begin
                // Unwind every level at once, back to the outermost caller.
                state         <= IDLE;
                sel_q         <= '0;
                depth_q       <= '0;
                redir_valid_q <= 1'b1;
                redir_pc_q    <= stack_pc[0];
                wdt_abort_q   <= 1'b1;
                wdt_cnt       <= '0;
            end else begin
                if (do_start || do_end) begin
                    wdt_cnt <= '0;
                end else if (state == RUN && !bus.stall) begin
                    wdt_cnt <= wdt_cnt + 1'b1;
                end
`endif
                if (do_end) begin
                    sel_q         <= stack_sel[pop_idx];
                    depth_q       <= depth_q - 1'b1;
                    redir_valid_q <= 1'b1;
                    redir_pc_q    <= stack_pc[pop_idx];
                    state         <= (depth_q == DEP_W'(1)) ? IDLE : RUN;
                end else if (do_start) begin
                    sel_q         <= SEL_W'(bus.start_id) + SEL_W'(1);
                    depth_q       <= depth_q + 1'b1;
                    redir_valid_q <= 1'b1;
                    redir_pc_q    <= ROUTINE_BASE;
                    state         <= RUN;
                end
`ifdef UCODE_WATCHDOG_EN
            end
`endif
        end
    end

    assign bus.im_sel      = sel_q;
    assign bus.active      = (state == RUN);
    assign bus.depth       = depth_q;
    assign bus.redir_valid = redir_valid_q;
    assign bus.redir_pc    = redir_pc_q;
    assign bus.err         = err_q;
    assign bus.wdt_abort   = wdt_abort_q;

endmodule
